// File: rtl/fifo_rd_packer_if.sv
// Output stream bundle for fifo_rd_packer.
//   m_data  : packed word, byte 0 in the low bits
//   m_keep  : byte-valid mask, contiguous from bit 0
//   m_last  : word was closed by flush or idle timeout
//   m_valid : word valid (held until accepted)
//   m_ready : downstream accept
// master = the packer, slave = the consumer.
interface fifo_rd_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_NUM   = 4
);
    logic [DATA_WIDTH*PACK_NUM-1:0] m_data;
    logic [PACK_NUM-1:0]            m_keep;
    logic                           m_last;
    logic                           m_valid;
    logic                           m_ready;

    modport master (
        output m_data, m_keep, m_last, m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data, m_keep, m_last, m_valid,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains bytes from an 8-bit FIFO read port and packs them
// little-endian into PACK_NUM-byte words on a valid/ready stream. A flush
// request or an idle timeout closes a partial word with byte-keep.
// Ports:
//   rd_clk, rd_rst : clock, synchronous active-high reset
//   fifo_rd_en     : pop request (combinational from state and fifo_empty)
//   fifo_rd_data   : read data, valid RD_LATENCY cycles after fifo_rd_en
//   fifo_empty     : FIFO empty flag
//   flush          : request emission of the current partial word
//   m_if           : output stream (master modport)
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_NUM   = 4,
    parameter int RD_LATENCY = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic                  flush,
    fifo_rd_packer_if.master      m_if
);

    localparam int              CW       = $clog2(PACK_NUM + 1);
    localparam int              WW       = DATA_WIDTH * PACK_NUM;
    localparam logic [CW-1:0]   FULL     = CW'(PACK_NUM);
    // Idle timer counts down from TIMEOUT-1; reaching zero while still idle
    // is the expiry.
    localparam logic [9:0]      TMR_LOAD = 10'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CW-1:0]         reserved_q, reserved_d;
    logic [CW-1:0]         arrived_q, arrived_d;
    logic [WW-1:0]         asm_q, asm_d;
    logic [RD_LATENCY-1:0] pipe_q, pipe_d;
    logic                  flush_pend_q, flush_pend_d;
    logic [9:0]            tmr_q, tmr_d;
    logic [WW-1:0]         m_data_q, m_data_d;
    logic [PACK_NUM-1:0]   m_keep_q, m_keep_d;
    logic                  m_last_q, m_last_d;
    logic                  m_valid_q, m_valid_d;

    logic                  load_ok;
    logic                  arrive;
    logic                  drained;
    logic                  full_close;
    logic                  part_close;
    logic                  pop;
    logic                  tmr_run;
    logic                  tmr_fire;
    logic [PACK_NUM-1:0]   keep_part;

    always_comb begin
        load_ok    = !m_valid_q || m_if.m_ready;
        arrive     = pipe_q[RD_LATENCY-1];
        drained    = (reserved_q == arrived_q);
        full_close = (arrived_q == FULL) && load_ok;
        part_close = flush_pend_q && (arrived_q != '0) && drained && load_ok;

        // Once a flush is pending and nothing is in flight, stop popping so
        // the partial word closes instead of growing.
        pop = !rd_rst && !fifo_empty && (reserved_q < FULL) && !part_close
              && !(flush_pend_q && drained);

        tmr_run  = (arrived_q != '0) && drained && fifo_empty;
        tmr_fire = (TIMEOUT != 0) && tmr_run && (tmr_q == '0) && !flush_pend_q;

        for (int i = 0; i < PACK_NUM; i++) begin
            keep_part[i] = (CW'(i) < arrived_q);
        end
    end

    assign fifo_rd_en = pop;

    always_comb begin
        pipe_d       = pipe_q;
        reserved_d   = reserved_q;
        arrived_d    = arrived_q;
        asm_d        = asm_q;
        flush_pend_d = flush_pend_q;
        tmr_d        = tmr_q;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        m_last_d     = m_last_q;
        m_valid_d    = m_valid_q;

        pipe_d[0] = pop;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        // A close implies nothing is in flight, so close and arrival never
        // coincide; clearing the assembly zeroes unused lanes of a partial.
        if (full_close || part_close) begin
            reserved_d = '0;
            arrived_d  = '0;
            asm_d      = '0;
        end else begin
            if (pop) begin
                reserved_d = reserved_q + CW'(1);
            end
            if (arrive) begin
                arrived_d = arrived_q + CW'(1);
                for (int i = 0; i < PACK_NUM; i++) begin
                    if (arrived_q == CW'(i)) begin
                        asm_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
                    end
                end
            end
        end

        if (m_valid_q && m_if.m_ready) begin
            m_valid_d = 1'b0;
        end
        if (full_close) begin
            m_data_d  = asm_q;
            m_keep_d  = '1;
            m_last_d  = flush_pend_q;
            m_valid_d = 1'b1;
        end else if (part_close) begin
            m_data_d  = asm_q;
            m_keep_d  = keep_part;
            m_last_d  = 1'b1;
            m_valid_d = 1'b1;
        end

        if (full_close || part_close) begin
            flush_pend_d = 1'b0;
        end
        // A flush with nothing assembled or in flight has nothing to emit.
        if (flush_pend_q && (reserved_q == '0) && (arrived_q == '0)) begin
            flush_pend_d = 1'b0;
        end
        if (flush || tmr_fire) begin
            flush_pend_d = 1'b1;
        end

        if (!tmr_run || pop || arrive || full_close || part_close) begin
            tmr_d = TMR_LOAD;
        end else if (tmr_q != '0) begin
            tmr_d = tmr_q - 10'd1;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            pipe_q       <= '0;
            reserved_q   <= '0;
            arrived_q    <= '0;
            asm_q        <= '0;
            flush_pend_q <= 1'b0;
            tmr_q        <= TMR_LOAD;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_last_q     <= 1'b0;
            m_valid_q    <= 1'b0;
        end else begin
            pipe_q       <= pipe_d;
            reserved_q   <= reserved_d;
            arrived_q    <= arrived_d;
            asm_q        <= asm_d;
            flush_pend_q <= flush_pend_d;
            tmr_q        <= tmr_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_last_q     <= m_last_d;
            m_valid_q    <= m_valid_d;
        end
    end

    assign m_if.m_data  = m_data_q;
    assign m_if.m_keep  = m_keep_q;
    assign m_if.m_last  = m_last_q;
    assign m_if.m_valid = m_valid_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer. dut_a: RD_LATENCY=1, TIMEOUT=8.
// dut_b: RD_LATENCY=2, TIMEOUT=64. Each has a small FIFO model.
module tb_fifo_rd_packer;

    logic rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    logic       rd_rst;
    logic       rd_en_a, rd_en_b;
    logic       empty_a, empty_b;
    logic       flush_a, flush_b;
    logic [7:0] rd_data_a = '0;
    logic [7:0] rd_data_b = '0;
    logic [7:0] stage_b   = '0;

    fifo_rd_packer_if #(.DATA_WIDTH(8), .PACK_NUM(4)) s_a ();
    fifo_rd_packer_if #(.DATA_WIDTH(8), .PACK_NUM(4)) s_b ();

    fifo_rd_packer #(.DATA_WIDTH(8), .PACK_NUM(4), .RD_LATENCY(1), .TIMEOUT(8)) dut_a (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .fifo_rd_en   (rd_en_a),
        .fifo_rd_data (rd_data_a),
        .fifo_empty   (empty_a),
        .flush        (flush_a),
        .m_if         (s_a.master)
    );

    fifo_rd_packer #(.DATA_WIDTH(8), .PACK_NUM(4), .RD_LATENCY(2), .TIMEOUT(64)) dut_b (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .fifo_rd_en   (rd_en_b),
        .fifo_rd_data (rd_data_b),
        .fifo_empty   (empty_b),
        .flush        (flush_b),
        .m_if         (s_b.master)
    );

    // FIFO models: memory and write pointer owned by the stimulus, read
    // pointer owned by the pop process.
    logic [7:0] mem_a [0:255];
    logic [7:0] mem_b [0:255];
    logic [7:0] wr_a = '0, rd_a = '0;
    logic [7:0] wr_b = '0, rd_b = '0;
    int         underflow = 0;

    assign empty_a = (wr_a == rd_a);
    assign empty_b = (wr_b == rd_b);

    always @(posedge rd_clk) begin
        if (rd_en_a) begin
            if (rd_a == wr_a) begin
                underflow <= underflow + 1;
            end else begin
                rd_data_a <= mem_a[rd_a];
                rd_a      <= rd_a + 8'd1;
            end
        end
    end

    always @(posedge rd_clk) begin
        if (rd_en_b && (rd_b != wr_b)) begin
            stage_b <= mem_b[rd_b];
            rd_b    <= rd_b + 8'd1;
        end
        rd_data_b <= stage_b;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push_a(input logic [7:0] v);
        mem_a[wr_a] = v;
        wr_a        = wr_a + 8'd1;
    endtask

    task automatic push_b(input logic [7:0] v);
        mem_b[wr_b] = v;
        wr_b        = wr_b + 8'd1;
    endtask

    // Observe dut_a for n cycles: pops issued, first cycle with m_valid,
    // number of valid cycles, and the last word seen.
    task automatic run_a(input int n, output int pops, output int first_v, output int nv,
                         output logic [31:0] d, output logic [3:0] k, output logic l);
        logic [7:0] start;
        start   = rd_a;
        first_v = -1;
        nv      = 0;
        d       = '0;
        k       = '0;
        l       = 1'b0;
        for (int c = 0; c < n; c++) begin
            if (s_a.m_valid) begin
                if (first_v < 0) first_v = c;
                nv++;
                d = s_a.m_data;
                k = s_a.m_keep;
                l = s_a.m_last;
            end
            @(negedge rd_clk);
        end
        pops = int'(rd_a - start);
    endtask

    int          pops, first_v, nv, nw;
    logic [31:0] d, held;
    logic [3:0]  k;
    logic        l, changed, any_en, any_v, fp1, fp2;
    logic [31:0] words [0:7];

    initial begin
        rd_rst      = 1'b1;
        flush_a     = 1'b0;
        flush_b     = 1'b0;
        s_a.m_ready = 1'b1;
        s_b.m_ready = 1'b1;
        repeat (2) @(negedge rd_clk);

        // reset state
        check_val("rst_valid", s_a.m_valid, 1'b0);
        check_val("rst_keep",  s_a.m_keep, 4'h0);
        check_val("rst_data",  s_a.m_data, 32'h0);
        check_val("rst_last",  s_a.m_last, 1'b0);
        check_val("rst_rd_en", rd_en_a, 1'b0);
        rd_rst = 1'b0;
        @(negedge rd_clk);

        // full word, RD_LATENCY=1
        push_a(8'h11); push_a(8'h22); push_a(8'h33); push_a(8'h44);
        #1;
        run_a(15, pops, first_v, nv, d, k, l);
        check_val("full_pops",  pops, 4);
        check_val("full_first", first_v, 6);
        check_val("full_nv",    nv, 1);
        check_val("full_data",  d, 32'h44332211);
        check_val("full_keep",  k, 4'b1111);
        check_val("full_last",  l, 1'b0);

        // idle timeout
        push_a(8'hA5);
        #1;
        run_a(20, pops, first_v, nv, d, k, l);
        check_val("to_pops",  pops, 1);
        check_val("to_first", first_v, 11);
        check_val("to_data",  d, 32'h000000A5);
        check_val("to_keep",  k, 4'b0001);
        check_val("to_last",  l, 1'b1);

        // flush with a pop in flight, RD_LATENCY=2
        push_b(8'h01); push_b(8'h02);
        #1;
        first_v = -1;
        d = '0; k = '0; l = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (s_b.m_valid) begin
                if (first_v < 0) first_v = c;
                d = s_b.m_data;
                k = s_b.m_keep;
                l = s_b.m_last;
            end
            flush_b = (c == 2);
            @(negedge rd_clk);
        end
        flush_b = 1'b0;
        check_val("fl_first", first_v, 5);
        check_val("fl_data",  d, 32'h00000201);
        check_val("fl_keep",  k, 4'b0011);
        check_val("fl_last",  l, 1'b1);
        check_val("fl_pops",  rd_b, 8'd2);

        // backpressure
        s_a.m_ready = 1'b0;
        for (int i = 0; i < 12; i++) push_a(8'(i));
        #1;
        begin
            logic [7:0] start;
            start   = rd_a;
            held    = '0;
            changed = 1'b0;
            nv      = 0;
            for (int c = 0; c < 30; c++) begin
                if (s_a.m_valid) begin
                    if (nv == 0) held = s_a.m_data;
                    else if (s_a.m_data != held) changed = 1'b1;
                    nv++;
                end
                @(negedge rd_clk);
            end
            check_val("bp_pops",    int'(rd_a - start), 8);
            check_val("bp_held",    held, 32'h03020100);
            check_val("bp_stable",  changed, 1'b0);
            check_val("bp_keep",    s_a.m_keep, 4'b1111);
        end
        s_a.m_ready = 1'b1;
        nw = 0;
        for (int c = 0; c < 30; c++) begin
            if (s_a.m_valid && s_a.m_ready) begin
                if (nw < 8) words[nw] = s_a.m_data;
                nw++;
            end
            @(negedge rd_clk);
        end
        check_val("bp_nwords", nw, 3);
        check_val("bp_w0", words[0], 32'h03020100);
        check_val("bp_w1", words[1], 32'h07060504);
        check_val("bp_w2", words[2], 32'h0B0A0908);
        check_val("bp_last", s_a.m_last, 1'b0);

        // reset mid-word with a full word held and one byte in flight
        s_a.m_ready = 1'b0;
        push_a(8'hD0); push_a(8'hD1); push_a(8'hD2); push_a(8'hD3);
        push_a(8'hC0); push_a(8'hC1); push_a(8'hC2);
        #1;
        for (int c = 0; c < 10; c++) begin
            rd_rst = (c == 9);
            @(negedge rd_clk);
        end
        check_val("mr_valid", s_a.m_valid, 1'b0);
        check_val("mr_data",  s_a.m_data, 32'h0);
        check_val("mr_keep",  s_a.m_keep, 4'h0);
        check_val("mr_last",  s_a.m_last, 1'b0);
        rd_rst      = 1'b0;
        s_a.m_ready = 1'b1;
        @(negedge rd_clk);
        push_a(8'hB0); push_a(8'hB1); push_a(8'hB2); push_a(8'hB3);
        #1;
        run_a(15, pops, first_v, nv, d, k, l);
        check_val("mr_pops", pops, 4);
        check_val("mr_word", d, 32'hB3B2B1B0);
        check_val("mr_nv",   nv, 1);
        check_val("mr_keep2", k, 4'b1111);

        // flush with nothing assembled and the FIFO empty
        any_en = 1'b0;
        any_v  = 1'b0;
        fp1    = 1'b0;
        fp2    = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (rd_en_a) any_en = 1'b1;
            if (s_a.m_valid) any_v = 1'b1;
            if (c == 1) fp1 = dut_a.flush_pend_q;
            if (c == 2) fp2 = dut_a.flush_pend_q;
            flush_a = (c == 0);
            @(negedge rd_clk);
        end
        flush_a = 1'b0;
        check_val("em_rd_en",   any_en, 1'b0);
        check_val("em_valid",   any_v, 1'b0);
        check_val("em_fp_set",  fp1, 1'b1);
        check_val("em_fp_clr",  fp2, 1'b0);

        check_val("underflow", underflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
